// File: rtl/dec_line_pkg.sv
// Shared constants and state type for the ASCII decimal line parser.
// Imported by ascii_class and dec_line_parser.
package dec_line_pkg;

    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_SP = 8'h20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/dec_line_parser_ascii_class.sv
// Combinational ASCII classifier: char_data in; is_digit, is_term
// (CR/LF), is_space and digit (low nibble, meaningful when is_digit).
module ascii_class
    import dec_line_pkg::*;
(
    input  logic [7:0] char_data,
    output logic       is_digit,
    output logic       is_term,
    output logic       is_space,
    output logic [3:0] digit
);

    assign is_digit = (char_data >= CH_0)
                   && (char_data <= CH_9);
    assign is_term  = (char_data == CH_CR)
                   || (char_data == CH_LF);
    assign is_space = (char_data == CH_SP);
    assign digit    = char_data[3:0];

endmodule

// File: rtl/dec_line_parser.sv
// ASCII decimal line to WIDTH-bit binary; value_valid/err pulse on CR/LF.
// Ports: clk, rst_n, char_valid/char_data/char_ready, value, value_valid, err, busy.
module dec_line_parser
    import dec_line_pkg::*;
#(
    parameter int WIDTH     = 14,
    parameter int MAX_CHARS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             char_valid,
    input  logic [7:0]       char_data,
    output logic             char_ready,
    output logic [WIDTH-1:0] value,
    output logic             value_valid,
    output logic             err,
    output logic             busy
);

    localparam int CW = $clog2(MAX_CHARS + 1);

    logic             is_digit;
    logic             is_term;
    logic             is_space;
    logic [3:0]       digit;
    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             ovf;
    logic             bad;
    logic             take;
    logic             cnt_full;
    logic [WIDTH+3:0] acc_x;
    logic [WIDTH+3:0] prod;

    ascii_class u_cls (
        .char_data (char_data),
        .is_digit  (is_digit),
        .is_term   (is_term),
        .is_space  (is_space),
        .digit     (digit)
    );

    assign char_ready = (state != EMIT);
    assign busy       = (state == ACCUM);
    assign take       = char_valid && char_ready;
    assign cnt_full   = (cnt == CW'(MAX_CHARS));

    // acc*10 + d with 4 guard bits; any guard bit set means overflow
    assign acc_x = {4'b0000, acc};
    assign prod  = (acc_x << 3) + (acc_x << 1)
                 + {{WIDTH{1'b0}}, digit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            bad         <= 1'b0;
            value       <= '0;
            value_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            err         <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (take) begin
                        unique case (1'b1)
                            is_digit: begin
                                acc   <= WIDTH'(digit);
                                cnt   <= CW'(1);
                                ovf   <= 1'b0;
                                bad   <= 1'b0;
                                state <= ACCUM;
                            end
                            (is_term | is_space): begin
                            end
                            default: begin
                                acc   <= '0;
                                cnt   <= CW'(1);
                                ovf   <= 1'b0;
                                bad   <= 1'b1;
                                state <= ACCUM;
                            end
                        endcase
                    end
                end
                ACCUM: begin
                    if (take) begin
                        if (is_term) begin
                            // result registered here so it is visible in EMIT
                            state <= EMIT;
                            if (ovf || bad) begin
                                err <= 1'b1;
                            end else begin
                                value       <= acc;
                                value_valid <= 1'b1;
                            end
                        end else begin
                            if (is_digit) begin
                                if (|prod[WIDTH+3:WIDTH])
                                    ovf <= 1'b1;
                                else
                                    acc <= prod[WIDTH-1:0];
                            end else begin
                                bad <= 1'b1;
                            end
                            if (cnt_full)
                                ovf <= 1'b1;
                            else
                                cnt <= cnt + CW'(1);
                        end
                    end
                end
                EMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_line_parser.sv
// Self-checking bench for dec_line_parser: table vectors, timing
// sequences, reset mid-line and random lines against a numeric model.
module tb_dec_line_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready;
    logic [13:0] value;
    logic        value_valid;
    logic        err;
    logic        busy;

    int total = 0;
    int nbad = 0;
    int vv_cnt = 0;
    int er_cnt = 0;
    int busy_cnt = 0;
    int exp_val = 0;

    dec_line_parser #(.WIDTH(14), .MAX_CHARS(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .char_valid  (char_valid),
        .char_data   (char_data),
        .char_ready  (char_ready),
        .value       (value),
        .value_valid (value_valid),
        .err         (err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (value_valid) vv_cnt++;
            if (err) er_cnt++;
            if (busy) busy_cnt++;
            if (value_valid || err)
                check("pulse_excl", int'(value_valid && err), 0);
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit r;
        int cyc;
        if (gap) begin
            char_valid = 1'b0;
            @(negedge clk);
        end
        char_valid = 1'b1;
        char_data  = b;
        cyc = 0;
        forever begin
            r = char_ready;
            @(posedge clk);
            @(negedge clk);
            if (r) break;
            cyc++;
            if (cyc > 8) begin
                check("ready_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic run_line(input string nm, input byte q[$],
                            input int ev, input int ee,
                            input int val, input bit gaps);
        vv_cnt = 0;
        er_cnt = 0;
        foreach (q[i])
            send_byte(q[i], gaps && ($urandom_range(0, 4) == 0));
        char_valid = 1'b0;
        repeat (3) @(negedge clk);
        if (ev != 0) exp_val = val;
        check({nm, ".vv"}, vv_cnt, ev);
        check({nm, ".err"}, er_cnt, ee);
        check({nm, ".value"}, int'(value), exp_val);
    endtask

    typedef struct packed {
        logic [63:0] txt;
        logic [4:0]  len;
        logic        ev;
        logic        ee;
        logic [13:0] val;
    } vec_t;

    function automatic vec_t mk(input logic [63:0] t, input int l,
                                input bit v, input bit e,
                                input int x);
        vec_t r;
        r.txt = t;
        r.len = 5'(l);
        r.ev  = v;
        r.ee  = e;
        r.val = 14'(x);
        return r;
    endfunction

    initial begin
        vec_t tbl[12];
        byte  q[$];
        byte  pool[5];
        bit   r0;

        tbl[0]  = mk("1234\r",   5, 1, 0, 1234);
        tbl[1]  = mk("16383\n",  6, 1, 0, 16383);
        tbl[2]  = mk("16384\r",  6, 0, 1, 0);
        tbl[3]  = mk("12a4\r",   5, 0, 1, 0);
        tbl[4]  = mk("\r\n\r\n", 4, 0, 0, 0);
        tbl[5]  = mk("42\r\n",   4, 1, 0, 42);
        tbl[6]  = mk("007\r",    4, 1, 0, 7);
        tbl[7]  = mk("a\r",      2, 0, 1, 0);
        tbl[8]  = mk("5 \r",     3, 0, 1, 0);
        tbl[9]  = mk(" 8\r",     3, 1, 0, 8);
        tbl[10] = mk("65535\r",  6, 0, 1, 0);
        tbl[11] = mk("0\r",      2, 1, 0, 0);

        // reset state
        repeat (2) @(negedge clk);
        check("rst.value", int'(value), 0);
        check("rst.vv", int'(value_valid), 0);
        check("rst.err", int'(err), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.ready", int'(char_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // exact timing of "1234\r" streamed back-to-back
        vv_cnt = 0;
        er_cnt = 0;
        send_byte("1", 0);
        check("t.busy", int'(busy), 1);
        send_byte("2", 0);
        send_byte("3", 0);
        send_byte("4", 0);
        char_data = 8'h0D;
        r0 = char_ready;
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
        check("t.rdy_before", int'(r0), 1);
        check("t.vv_n1", int'(value_valid), 1);
        check("t.val_n1", int'(value), 1234);
        check("t.err_n1", int'(err), 0);
        check("t.rdy_n1", int'(char_ready), 0);
        check("t.busy_n1", int'(busy), 0);
        @(negedge clk);
        check("t.vv_n2", int'(value_valid), 0);
        check("t.rdy_n2", int'(char_ready), 1);
        repeat (2) @(negedge clk);
        check("t.vv_total", vv_cnt, 1);
        check("t.err_total", er_cnt, 0);
        exp_val = 1234;

        // table vectors
        foreach (tbl[k]) begin
            q.delete();
            for (int i = 0; i < int'(tbl[k].len); i++)
                q.push_back(tbl[k].txt[8*(int'(tbl[k].len)-1-i) +: 8]);
            busy_cnt = 0;
            run_line($sformatf("tbl%0d", k), q, int'(tbl[k].ev),
                     int'(tbl[k].ee), int'(tbl[k].val), 0);
            if (k == 4) check("tbl4.busy", busy_cnt, 0);
        end

        // line length limits
        q.delete();
        repeat (17) q.push_back("0");
        q.push_back(8'h0D);
        run_line("zeros17", q, 0, 1, 0, 0);
        q.delete();
        repeat (16) q.push_back("0");
        q.push_back(8'h0D);
        run_line("zeros16", q, 1, 0, 0, 0);

        // reset mid-line discards the partial line
        exp_val = 123;
        q = '{"1", "2", "3", 8'h0D};
        run_line("pre_rst", q, 1, 0, 123, 0);
        vv_cnt = 0;
        er_cnt = 0;
        send_byte("9", 0);
        send_byte("9", 0);
        char_valid = 1'b0;
        check("mid.busy", int'(busy), 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid.busy_rst", int'(busy), 0);
        check("mid.value_rst", int'(value), 0);
        check("mid.ready_rst", int'(char_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid.no_pulse", vv_cnt + er_cnt, 0);
        exp_val = 0;
        q = '{"7", 8'h0D};
        run_line("post_rst", q, 1, 0, 7, 0);

        // random lines against a numeric model
        pool = '{"x", "-", ":", " ", "A"};
        for (int n = 0; n < 200; n++) begin
            int  blen;
            int  nsp;
            bit  isbad;
            bit  big;
            longint v;
            byte c;
            q.delete();
            nsp = $urandom_range(0, 2);
            repeat (nsp) q.push_back(" ");
            if ($urandom_range(0, 7) == 0)
                blen = $urandom_range(13, 19);
            else
                blen = $urandom_range(1, 6);
            isbad = 0;
            big = 0;
            v = 0;
            for (int i = 0; i < blen; i++) begin
                if ($urandom_range(0, 9) < 9) begin
                    c = 8'(8'h30 + $urandom_range(0, 9));
                end else begin
                    c = pool[$urandom_range(0, 4)];
                    if (i == 0 && c == " ") c = "x";
                end
                q.push_back(c);
                if (c >= "0" && c <= "9") begin
                    if (!big) v = v * 10 + longint'(c - 8'h30);
                    if (v > 16383) big = 1;
                end else begin
                    isbad = 1;
                end
            end
            q.push_back($urandom_range(0, 1) ? 8'h0D : 8'h0A);
            if ($urandom_range(0, 2) == 0) q.push_back(8'h0A);
            if (isbad || big || blen > 16)
                run_line($sformatf("rnd%0d", n), q, 0, 1, 0, 1);
            else
                run_line($sformatf("rnd%0d", n), q, 1, 0, int'(v), 1);
        end

        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end

endmodule
